// File: rtl/rx_pkg.sv
// Shared definitions for the receive-port arbiter: FSM states, header field
// positions and the packet-length clamp used to size each data burst.
package rx_pkg;

  typedef enum logic {
    ARB    = 1'b0,
    STREAM = 1'b1
  } rx_state_e;

  localparam int HDR_DST_MSB = 31;
  localparam int HDR_DST_LSB = 24;
  localparam int HDR_SRC_MSB = 23;
  localparam int HDR_SRC_LSB = 16;
  localparam int HDR_LEN_MSB = 15;
  localparam int HDR_LEN_LSB = 8;

  localparam int unsigned MAX_WORDS_DEFAULT = 8;

  // Byte length to data-flit count; the receiver needs at least one data flit
  // and cannot buffer more than max_words.
  function automatic int unsigned clamp_words(input logic [7:0] len_bytes,
                                              input int unsigned max_words);
    int unsigned words;
    words = {24'd0, len_bytes} >> 2;
    if (words == 0) begin
      words = 1;
    end else if (words > max_words) begin
      words = max_words;
    end
    return words;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request bit searching upward
// from last+1, wrapping modulo N.
module rr_picker #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic          valid,
  output logic [IW-1:0] idx
);

  logic          found;
  logic [IW-1:0] cand;

  // NOTE: every output and temporary gets a default at the top of the block;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    valid = |req;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int off = 1; off <= N; off++) begin
      cand = IW'((int'(last) + off) % N);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/rx_port_arbiter.sv
// Round-robin share of the node's single receive port between N router
// channels: header forwarded combinationally, then the owner streams its data.
module rx_port_arbiter
  import rx_pkg::*;
#(
  parameter int          N         = 4,
  parameter int unsigned MAX_WORDS = MAX_WORDS_DEFAULT
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic [N-1:0]  M_Req,
  input  logic [32*N-1:0] M_Data,
  output logic [N-1:0]  M_Ack,
  output logic          S_Req,
  output logic [31:0]   S_Data,
  input  logic          S_Ack,
  output logic [N-1:0]  Grant,
  output logic          Busy
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(MAX_WORDS + 1);

  rx_state_e     state_q, state_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [IW-1:0] last_q,  last_d;
  logic [CW-1:0] cnt_q,   cnt_d;

  logic [31:0]   chan_data [N];
  logic          pick_valid;
  logic [IW-1:0] pick_idx;
  logic [31:0]   win_hdr;

  for (genvar i = 0; i < N; i++) begin : g_slice
    assign chan_data[i] = M_Data[32*i +: 32];
  end

  rr_picker #(.N(N), .IW(IW)) u_picker (
    .req   (M_Req),
    .last  (last_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign win_hdr = chan_data[pick_idx];

  // NOTE: state registers use non-blocking assignments so every flop samples
  // its pre-edge value regardless of evaluation order.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= ARB;
      owner_q <= '0;
      last_q  <= IW'(N - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    S_Req   = 1'b0;
    S_Data  = '0;
    M_Ack   = '0;
    Grant   = '0;
    Busy    = 1'b0;

    // Outputs are forced idle while reset is held, since the header path is
    // combinational from M_Req/S_Ack.
    if (HRESETn) begin
      unique case (state_q)
        ARB: begin
          if (S_Ack && pick_valid) begin
            S_Req           = 1'b1;
            S_Data          = win_hdr;
            M_Ack[pick_idx] = 1'b1;
            owner_d         = pick_idx;
            last_d          = pick_idx;
            cnt_d           = CW'(clamp_words(win_hdr[HDR_LEN_MSB:HDR_LEN_LSB],
                                              MAX_WORDS));
            state_d         = STREAM;
          end
        end
        STREAM: begin
          Busy           = 1'b1;
          Grant[owner_q] = 1'b1;
          S_Data         = chan_data[owner_q];
          M_Ack[owner_q] = 1'b1;
          cnt_d          = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_d = ARB;
          end
        end
        default: state_d = ARB;
      endcase
    end
  end

endmodule

// File: doc/rx_port_arbiter.md
# rx_port_arbiter

- Shares the single network receive port of a node's AHB receive interface between `N` network input channels (one per neighbour link).
- Selects one requesting channel round-robin and forwards its header flit on the receive handshake.
- Holds the grant while that channel streams its data flits, then releases for the next packet.
- Sits between the router's output channels and the receive slave's `S_Req/S_Ack/S_Data` port.

## Interface
- `N`, 4, number of input channels (2..8).
- `MAX_WORDS`, 8, maximum data flits per packet (receive buffer depth).
- `HCLK`  in  1  clock.
- `HRESETn`  in  1  reset; asynchronous, active-low.
- `M_Req`  in  N  channel i has a header flit on `M_Data[i]`.
- `M_Data`  in  32*N  flit from channel i, bits [32i+31:32i].
- `M_Ack`  out  N  flit of channel i consumed this cycle.
- `S_Req`  out  1  header valid toward the receive slave.
- `S_Data`  out  32  flit toward the receive slave.
- `S_Ack`  in  1  receive slave is empty and samples a header this cycle.
- `Grant`  out  N  one-hot owner during streaming; 0 otherwise.
- `Busy`  out  1  packet streaming in progress.

## Operation
- Header fields: [31:24] destination, [23:16] source, [15:8] byte length.
- Data-word count = byte length >> 2, clamped:
  - result 0 → 1
  - result > `MAX_WORDS` → `MAX_WORDS`
- The receive slave needs at least one data flit per header and has no flow control on data.
- States: `ARB`, `STREAM`.
- `ARB` (reset state):
  - Winner = first set bit of `M_Req`, searching from `last+1` and wrapping modulo `N`. `last` resets to `N-1`, so channel 0 has top priority after reset.
  - If `S_Ack`=1 and `M_Req`≠0: `S_Req`=1, `S_Data`=winner's flit, `M_Ack[winner]`=1.
  - Also register `owner`=winner, `cnt`=clamped count, `last`=winner; go to `STREAM`.
  - Otherwise `S_Req`=0 and stay in `ARB`. This includes the case where `S_Ack`=0 because the receiver is still holding an unread packet.
- `STREAM`:
  - `S_Req`=0, `S_Data`=`M_Data[owner]`, `M_Ack[owner]`=1 every cycle, `cnt` decrements.
  - When `cnt`=1, return to `ARB` next cycle.
  - The owner's `M_Req` is ignored; the owner must present one flit per cycle.
  - Other channels' `M_Req` are held off (`M_Ack`=0).
- `S_Data`=0 whenever no flit is forwarded. `M_Ack` is always at most one-hot.
- `Grant` = one-hot(`owner`) in `STREAM`, 0 in `ARB`. `Busy` = (state==`STREAM`).

## Timing
- Reset values: `S_Req`=0, `S_Data`=0, `M_Ack`=0, `Grant`=0, `Busy`=0, state=`ARB`, `cnt`=0, `last`=`N-1`.
- Header forwarding has zero latency: `M_Req`/`S_Ack` combinationally drive `S_Req`, `S_Data` and `M_Ack` in the same cycle.
- The k-th data flit (k=1..cnt) is forwarded k cycles after the header cycle, back-to-back.
- The earliest next header is the cycle after the last data flit, and only if `S_Ack`=1. The receiver normally holds `S_Ack` low until software drains it.
- `S_Ack` is ignored during `STREAM`.
- Simultaneous requests: exactly one is granted per header cycle. Losers keep `M_Req` asserted and see `M_Ack`=0.
- A `M_Req` rising during `STREAM` waits for `ARB`.
- Reset mid-packet: immediate return to reset values; any partial packet is abandoned.

## Structure
- Shared package `rx_pkg`:
  - state enum `{ARB, STREAM}`
  - header field positions (`HDR_DST_MSB/LSB`, `HDR_SRC_*`, `HDR_LEN_*`)
  - `MAX_WORDS` default
- One sub-module: `rr_picker`, combinational, parameter `N`. Inputs `req[N-1:0]`, `last`. Outputs `valid`, `idx`.
- The top level holds the FSM, `cnt`, `owner`, `last` and the output muxes.

## Test plan
- Reset, then channel 1 asserts header 32'h05_06_10_00 with `S_Ack`=1:
  - `S_Req`=1 and `M_Ack`=4'b0010 in the same cycle.
  - Then 4 data flits with `Grant`=4'b0010 and `Busy`=1.
  - Back to `ARB` on the 5th cycle.
- Channels 0, 2, 3 request continuously, `S_Ack` pulsed after each packet: grant order 0, 2, 3, 0 (round-robin wrap).
- Length 0x20 and length 0x40 headers: 8 data flits each (clamp). Length 0x02: exactly 1 data flit.
- `M_Req`=4'b0100 with `S_Ack`=0 for 10 cycles:
  - `S_Req`=0 and `M_Ack`=0 throughout.
  - Raising `S_Ack` grants channel 2 that cycle.
- Channel 3 requests during channel 0's `STREAM`: `M_Ack[3]` stays 0 until the first `ARB` cycle with `S_Ack`=1.
- `HRESETn` asserted on the 2nd data flit of an 8-flit packet: all outputs 0 immediately. After release, channel 0 has top priority.
